// File: rtl/video_timing_rx.sv
// video_timing_rx: measures sync geometry, qualifies lock over stable frames, regenerates active pixel coordinates
module video_timing_rx #(
  parameter int HW = 10,
  parameter int VW = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          CLK_32M,
  input  logic          reset,
  input  logic          CE_PIX,
  input  logic          HS,
  input  logic          VS,
  input  logic          HBLK,
  input  logic          VBLK,
  output logic          locked,
  output logic          line_start,
  output logic          frame_start,
  output logic          de,
  output logic [HW-1:0] px,
  output logic [VW-1:0] py,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [HW-1:0] hs_width,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic [VW-1:0] vs_width
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;
  localparam logic [HW-1:0] H1 = HW'(1);
  localparam logic [VW-1:0] V1 = VW'(1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [HW-1:0] sat_h(input logic [HW-1:0] x);
    return (x == HMAX) ? x : x + H1;
  endfunction

  function automatic logic [VW-1:0] sat_v(input logic [VW-1:0] x);
    return (x == VMAX) ? x : x + V1;
  endfunction

  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, hblk_prev_q, hblk_prev_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d, ha_cnt_q, ha_cnt_d, hw_cnt_q, hw_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d, vw_cnt_q, vw_cnt_d;
  logic [HW-1:0] h_total_q, h_total_d, h_active_q, h_active_d, hs_width_q, hs_width_d;
  logic [VW-1:0] v_total_q, v_total_d, v_active_q, v_active_d, vs_width_q, vs_width_d;
  logic          h_var_q, h_var_d, vfirst_q, vfirst_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d, de_q, de_d;
  logic [HW-1:0] px_q, px_d;
  logic [VW-1:0] py_q, py_d;
  state_t        state_q;
  logic [MW-1:0] match_q, match_nx;
  logic          locked_q;

  logic          hs_rise, hs_fall, vs_rise, vs_fall, hblk_fall;
  logic [HW-1:0] h_new;
  logic [VW-1:0] v_new, va_new;
  logic          h_chg, v_chg, frame_ok, sat;

  assign hs_rise   = CE_PIX & HS & ~hs_prev_q;
  assign hs_fall   = CE_PIX & ~HS & hs_prev_q;
  assign vs_rise   = CE_PIX & VS & ~vs_prev_q;
  assign vs_fall   = CE_PIX & ~VS & vs_prev_q;
  assign hblk_fall = CE_PIX & ~HBLK & hblk_prev_q;
  assign h_new     = sat_h(h_cnt_q);
  assign v_new     = hs_rise ? sat_v(v_cnt_q) : v_cnt_q;
  assign va_new    = (hs_rise & ~VBLK) ? sat_v(va_cnt_q) : va_cnt_q;
  assign h_chg     = hs_rise & (h_new != h_total_q);
  assign v_chg     = vs_rise & (v_new != v_total_q);
  assign frame_ok  = ~v_chg & ~h_var_q & ~h_chg;
  assign match_nx  = match_q + MW'(1);
  assign sat       = CE_PIX & ((h_cnt_d == HMAX) | (v_cnt_d == VMAX));

  // Next-state for measurement counters, latched geometry and coordinates; everything frozen when CE_PIX is low
  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hblk_prev_d   = hblk_prev_q;
    h_cnt_d       = h_cnt_q;
    ha_cnt_d      = ha_cnt_q;
    hw_cnt_d      = hw_cnt_q;
    v_cnt_d       = v_cnt_q;
    va_cnt_d      = va_cnt_q;
    vw_cnt_d      = vw_cnt_q;
    h_total_d     = h_total_q;
    h_active_d    = h_active_q;
    hs_width_d    = hs_width_q;
    v_total_d     = v_total_q;
    v_active_d    = v_active_q;
    vs_width_d    = vs_width_q;
    h_var_d       = h_var_q;
    vfirst_d      = vfirst_q;
    de_d          = de_q;
    px_d          = px_q;
    py_d          = py_q;
    line_start_d  = hs_rise;
    frame_start_d = vs_rise;
    if (CE_PIX) begin
      hs_prev_d   = HS;
      vs_prev_d   = VS;
      hblk_prev_d = HBLK;
      h_cnt_d     = hs_rise ? '0 : h_new;
      h_total_d   = hs_rise ? h_new : h_total_q;
      ha_cnt_d    = hs_rise ? (HBLK ? '0 : H1) : (HBLK ? ha_cnt_q : sat_h(ha_cnt_q));
      h_active_d  = hs_rise ? ha_cnt_q : h_active_q;
      hw_cnt_d    = hs_rise ? H1 : (HS ? sat_h(hw_cnt_q) : hw_cnt_q);
      hs_width_d  = hs_fall ? hw_cnt_q : hs_width_q;
      v_cnt_d     = vs_rise ? '0 : v_new;
      v_total_d   = vs_rise ? v_new : v_total_q;
      va_cnt_d    = vs_rise ? '0 : va_new;
      v_active_d  = vs_rise ? va_new : v_active_q;
      vw_cnt_d    = vs_rise ? (hs_rise ? V1 : '0) : ((hs_rise & VS) ? sat_v(vw_cnt_q) : vw_cnt_q);
      vs_width_d  = vs_fall ? vw_cnt_q : vs_width_q;
      h_var_d     = vs_rise ? 1'b0 : (h_var_q | h_chg);
      de_d        = ~HBLK & ~VBLK;
      px_d        = HBLK ? px_q : (hblk_prev_q ? '0 : px_q + H1);
      vfirst_d    = (hblk_fall & ~VBLK) ? 1'b0 : (vfirst_q | VBLK);
      py_d        = (hblk_fall & ~VBLK) ? (vfirst_q ? '0 : py_q + V1) : py_q;
    end
  end

  // Register datapath state; reset clears every counter, sample and output
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      hblk_prev_q   <= 1'b0;
      h_cnt_q       <= '0;
      ha_cnt_q      <= '0;
      hw_cnt_q      <= '0;
      v_cnt_q       <= '0;
      va_cnt_q      <= '0;
      vw_cnt_q      <= '0;
      h_total_q     <= '0;
      h_active_q    <= '0;
      hs_width_q    <= '0;
      v_total_q     <= '0;
      v_active_q    <= '0;
      vs_width_q    <= '0;
      h_var_q       <= 1'b0;
      vfirst_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      de_q          <= 1'b0;
      px_q          <= '0;
      py_q          <= '0;
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hblk_prev_q   <= hblk_prev_d;
      h_cnt_q       <= h_cnt_d;
      ha_cnt_q      <= ha_cnt_d;
      hw_cnt_q      <= hw_cnt_d;
      v_cnt_q       <= v_cnt_d;
      va_cnt_q      <= va_cnt_d;
      vw_cnt_q      <= vw_cnt_d;
      h_total_q     <= h_total_d;
      h_active_q    <= h_active_d;
      hs_width_q    <= hs_width_d;
      v_total_q     <= v_total_d;
      v_active_q    <= v_active_d;
      vs_width_q    <= vs_width_d;
      h_var_q       <= h_var_d;
      vfirst_q      <= vfirst_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      de_q          <= de_d;
      px_q          <= px_d;
      py_q          <= py_d;
    end
  end

  // Lock qualifier: counter saturation always falls back to SEARCH; lock needs LOCK_FRAMES clean frames
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q  <= SEARCH;
      match_q  <= '0;
      locked_q <= 1'b0;
    end else if (sat) begin
      state_q  <= SEARCH;
      match_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: if (vs_rise) begin
          state_q <= MEASURE;
          match_q <= '0;
        end
        MEASURE: if (vs_rise) begin
          match_q <= frame_ok ? match_nx : '0;
          if (frame_ok && match_nx == LOCK_N) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: if (h_chg | v_chg) begin
          state_q  <= MEASURE;
          match_q  <= '0;
          locked_q <= 1'b0;
        end
        default: begin
          state_q  <= SEARCH;
          match_q  <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked      = locked_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = de_q;
  assign px          = px_q;
  assign py          = py_q;
  assign h_total     = h_total_q;
  assign h_active    = h_active_q;
  assign hs_width    = hs_width_q;
  assign v_total     = v_total_q;
  assign v_active    = v_active_q;
  assign vs_width    = vs_width_q;
endmodule
